// File: rtl/mips_pkg.sv
// Shared constants for the five-stage MIPS pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

   // Canonical NOP: sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Register-specifier field positions inside an instruction word
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   // Register $0: a write to it is discarded, so it also means "no write"
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/id_ex_reg_pipe_field.sv
// Width-parameterised pipeline field register with hold and sync clear.
// Latency: 1 cycle from i_d to o_q.
// Backpressure: i_hold freezes the value and overrides i_clr; i_clr loads CLR_VAL.
module pipe_field #(
   parameter int             W       = 32,
   parameter logic [W-1:0]   CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_hold,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Priority hold > clear > load; reset is asynchronous
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_hold) begin
         r_q <= r_q;
      end else if (i_clr) begin
         r_q <= CLR_VAL;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : pipe_field

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: holds the decode bundle for execute, plus a bubble counter.
// Latency: 1 cycle from *_d to *_e; rs_e/rt_e are decoded combinationally from instr_e.
// Backpressure: hold freezes everything (a concurrent clr is dropped); clr inserts a NOP bubble.
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             hold,
   input  logic [31:0]      instr_d,
   input  logic [31:0]      pc8_d,
   input  logic [31:0]      rs_data_d,
   input  logic [31:0]      rt_data_d,
   input  logic [31:0]      imm32_d,
   input  logic [4:0]       a3_d,
   output logic [31:0]      instr_e,
   output logic [31:0]      pc8_e,
   output logic [31:0]      rs_data_e,
   output logic [31:0]      rt_data_e,
   output logic [31:0]      imm32_e,
   output logic [4:0]       a3_e,
   output logic [4:0]       rs_e,
   output logic [4:0]       rt_e,
   output logic             valid_e,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_bubble_cnt;

   pipe_field #(.W(32), .CLR_VAL(NOP_INSTR)) u_instr (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(instr_d), .o_q(instr_e)
   );

   pipe_field #(.W(32)) u_pc8 (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(pc8_d), .o_q(pc8_e)
   );

   pipe_field #(.W(32)) u_rs_data (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(rs_data_d), .o_q(rs_data_e)
   );

   pipe_field #(.W(32)) u_rt_data (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(rt_data_d), .o_q(rt_data_e)
   );

   pipe_field #(.W(32)) u_imm32 (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(imm32_d), .o_q(imm32_e)
   );

   // Bubbles write $0 so forwarding comparators can never match them
   pipe_field #(.W(5), .CLR_VAL(REG_ZERO)) u_a3 (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(a3_d), .o_q(a3_e)
   );

   // A load always carries a real instruction; a clear marks a bubble
   pipe_field #(.W(1), .CLR_VAL(1'b0)) u_valid (
      .clk(clk), .rst_n(reset), .i_hold(hold), .i_clr(clr), .i_d(1'b1), .o_q(valid_e)
   );

   // Count inserted bubbles, saturating at all-ones; frozen while held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubble_cnt <= '0;
      end else if (!hold && clr && (r_bubble_cnt != '1)) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
   assign rs_e       = instr_e[RS_MSB:RS_LSB];
   assign rt_e       = instr_e[RT_MSB:RT_LSB];

endmodule : id_ex_reg
